// File: rtl/pipe_out_pattern_pkg.sv
// Shared types and constants for the pipe-out pattern generator.
package pipe_out_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_SEED  = 2'd3
  } mode_e;

  localparam int unsigned LANE_W      = 32;
  localparam logic [31:0] LFSR_SEED0  = 32'h04030201;
  localparam logic [31:0] LANE_STRIDE = 32'h09090909;

  // Feedback taps for x^32 + x^22 + x^2 + 1
  localparam int unsigned TAP_A = 31;
  localparam int unsigned TAP_B = 21;
  localparam int unsigned TAP_C = 1;

  // Per-lane reset value; the LFSR lanes must never start at zero.
  function automatic logic [LANE_W-1:0] lane_init(input mode_e m,
                                                  input logic [LANE_W-1:0] seed,
                                                  input int unsigned idx);
    logic [LANE_W-1:0] stride;
    logic [LANE_W-1:0] v;
    stride = LANE_W'(idx) * LANE_STRIDE;
    case (m)
      MODE_LFSR: v = LFSR_SEED0 + stride;
      MODE_SEED: begin
        v = seed ^ stride;
        if (v == '0) v = LANE_W'(1);
      end
      default:   v = LANE_W'(1);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pipe_out_pattern_lane.sv
// One 32-bit generator lane: count, LFSR or walking-ones, advanced per read.
module pipe_out_pattern_lane
  import pipe_out_pattern_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LANE_W-1:0] load_val,
  input  logic              advance,
  input  mode_e             mode,
  output logic [LANE_W-1:0] lane
);

  logic [LANE_W-1:0] lane_nxt;

  always_comb begin
    lane_nxt = lane;
    case (mode)
      MODE_COUNT: lane_nxt = lane + LANE_W'(1);
      MODE_LFSR,
      MODE_SEED:  lane_nxt = {lane[LANE_W-2:0], lane[TAP_A] ^ lane[TAP_B] ^ lane[TAP_C]};
      MODE_WALK:  lane_nxt = {lane[LANE_W-2:0], lane[LANE_W-1]};
      default:    lane_nxt = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane <= load_val;
    end else if (advance) begin
      lane <= lane_nxt;
    end
  end

endmodule

// File: rtl/pipe_out_pattern_gen.sv
// Pipe-out test-data source: pattern lanes, throttled virtual FIFO level,
// ready/underflow flags and a read counter.
module pipe_out_pattern_gen
  import pipe_out_pattern_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned THROTTLE_W   = 32,
  parameter int unsigned LEVEL_W      = 16,
  parameter int unsigned LEVEL_MAX    = 65535,
  parameter int unsigned READY_THRESH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_out_read,
  output logic [DATA_W-1:0]     pipe_out_data,
  output logic                  pipe_out_ready,
  input  logic                  throttle_set,
  input  logic [THROTTLE_W-1:0] throttle_val,
  input  logic [1:0]            mode,
  input  logic [31:0]           seed_val,
  output logic                  underflow,
  output logic [31:0]           read_count
);

  localparam int unsigned NLANES = (DATA_W / LANE_W > 0) ? DATA_W / LANE_W : 1;
  localparam int unsigned BUS_W  = NLANES * LANE_W;
  localparam logic [LEVEL_W-1:0] LVL_MAX    = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LVL_THRESH = LEVEL_W'(READY_THRESH);

  mode_e                 mode_q;
  logic [BUS_W-1:0]      lane_bus;
  logic [THROTTLE_W-1:0] throttle;
  logic [LEVEL_W-1:0]    level;
  logic [LEVEL_W-1:0]    level_nxt;
  logic                  underflow_hit;

  // Mode is only honoured at reset so the stream never changes type mid-run.
  always_ff @(posedge clk) begin
    if (reset) mode_q <= mode_e'(mode);
  end

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    logic [LANE_W-1:0] load_val;
    assign load_val = lane_init(mode_e'(mode), seed_val, i);

    pipe_out_pattern_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .load_val (load_val),
      .advance  (pipe_out_read),
      .mode     (mode_q),
      .lane     (lane_bus[i*LANE_W +: LANE_W])
    );
  end

  if (BUS_W > DATA_W) begin : g_trim
    logic unused_hi;
    assign unused_hi = ^lane_bus[BUS_W-1:DATA_W];
  end

  always_ff @(posedge clk) begin
    if (reset) pipe_out_data <= '0;
    else       pipe_out_data <= lane_bus[DATA_W-1:0];
  end

  // Throttle mask rotates right; bit 0 is this cycle's virtual FIFO write.
  always_ff @(posedge clk) begin
    if (reset || throttle_set) throttle <= throttle_val;
    else                       throttle <= {throttle[0], throttle[THROTTLE_W-1:1]};
  end

  // A read with a simultaneous write is net-zero, even at an empty level.
  always_comb begin
    level_nxt     = level;
    underflow_hit = 1'b0;
    case ({pipe_out_read, throttle[0]})
      2'b01: if (level < LVL_MAX) level_nxt = level + LEVEL_W'(1);
      2'b10: begin
        if (level != '0) level_nxt = level - LEVEL_W'(1);
        else             underflow_hit = 1'b1;
      end
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level          <= '0;
      pipe_out_ready <= 1'b0;
      underflow      <= 1'b0;
      read_count     <= '0;
    end else begin
      level          <= level_nxt;
      pipe_out_ready <= (level >= LVL_THRESH);
      underflow      <= underflow | underflow_hit;
      read_count     <= read_count + 32'(pipe_out_read);
    end
  end

endmodule

// File: tb/tb_pipe_out_pattern_gen.sv
// Directed bench for pipe_out_pattern_gen at DATA_W 16, 32 and 64.
module tb_pipe_out_pattern_gen;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        tset;
  logic [31:0] tval;
  logic [1:0]  mode;
  logic [31:0] seed;

  logic [15:0] d16;
  logic [31:0] d32;
  logic [63:0] d64;
  logic        rdy16, rdy32, rdy64;
  logic        uf16, uf32, uf64;
  logic [31:0] rc16, rc32, rc64;

  int n_total;
  int n_bad;

  pipe_out_pattern_gen #(.DATA_W(16)) u_d16 (
    .clk(clk), .reset(reset), .pipe_out_read(rd), .pipe_out_data(d16),
    .pipe_out_ready(rdy16), .throttle_set(tset), .throttle_val(tval),
    .mode(mode), .seed_val(seed), .underflow(uf16), .read_count(rc16)
  );

  pipe_out_pattern_gen #(.DATA_W(32)) u_d32 (
    .clk(clk), .reset(reset), .pipe_out_read(rd), .pipe_out_data(d32),
    .pipe_out_ready(rdy32), .throttle_set(tset), .throttle_val(tval),
    .mode(mode), .seed_val(seed), .underflow(uf32), .read_count(rc32)
  );

  pipe_out_pattern_gen #(.DATA_W(64)) u_d64 (
    .clk(clk), .reset(reset), .pipe_out_read(rd), .pipe_out_data(d64),
    .pipe_out_ready(rdy64), .throttle_set(tset), .throttle_val(tval),
    .mode(mode), .seed_val(seed), .underflow(uf64), .read_count(rc64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset = 1'b1; rd = 1'b0; tset = 1'b0; tval = '0; mode = 2'd0; seed = '0;

    // Count mode, 16-bit: reset values, first word and single-read latency
    mode = 2'd0; tval = 32'h0;
    do_reset();
    chk("rst_data", 64'(d16), 64'h0);
    chk("rst_ready", 64'(rdy16), 64'h0);
    chk("rst_uf", 64'(uf16), 64'h0);
    chk("rst_rc", 64'(rc16), 64'h0);
    tick();
    chk("cnt_first", 64'(d16), 64'h0001);
    rd = 1'b1; tick(); rd = 1'b0;
    chk("cnt_lag", 64'(d16), 64'h0001);
    tick();
    chk("cnt_read", 64'(d16), 64'h0002);
    chk("cnt_rc1", 64'(rc16), 64'd1);

    // 65536 back-to-back reads wrap the 16-bit view back to 1
    do_reset();
    rd = 1'b1;
    repeat (65536) tick();
    rd = 1'b0;
    chk("cnt_wrap_pre", 64'(d16), 64'h0000);
    tick();
    chk("cnt_wrap", 64'(d16), 64'h0001);
    chk("cnt_rc_wrap", 64'(rc16), 64'd65536);

    // LFSR mode, 64-bit
    mode = 2'd1;
    do_reset();
    tick();
    chk("lfsr_first64", d64, 64'h0D0C0B0A_04030201);
    chk("lfsr_first16", 64'(d16), 64'h0201);
    rd = 1'b1; tick(); rd = 1'b0;
    tick();
    chk("lfsr_step64", d64, 64'h1A181615_08060402);

    // Walking ones, 32-bit, full rotation
    mode = 2'd2;
    do_reset();
    rd = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("walk_%0d", k), 64'(d32), 64'(32'h1 << (k - 1)));
    end
    rd = 1'b0;
    tick();
    chk("walk_wrap", 64'(d32), 64'h1);

    // Full-rate throttle: level hits threshold at edge 1024, ready one edge later
    mode = 2'd0; tval = 32'hFFFF_FFFF;
    do_reset();
    repeat (1024) tick();
    chk("ready_1024", 64'(rdy16), 64'h0);
    tick();
    chk("ready_1025", 64'(rdy16), 64'h1);

    // One write per 32 cycles: single write drained, net-zero at empty, then underflow
    tval = 32'h0000_0001;
    do_reset();
    repeat (31) tick();
    rd = 1'b1;
    tick();
    chk("slow_drain_uf", 64'(uf16), 64'h0);
    tick();
    chk("net_zero_uf", 64'(uf16), 64'h0);
    tick();
    rd = 1'b0;
    chk("slow_uf", 64'(uf16), 64'h1);
    chk("slow_rc", 64'(rc16), 64'd3);

    // Empty FIFO, no writes: read underflows and still counts
    tval = 32'h0;
    do_reset();
    chk("uf_clear", 64'(uf16), 64'h0);
    rd = 1'b1; tick(); rd = 1'b0;
    chk("uf_set", 64'(uf16), 64'h1);
    chk("uf_rc", 64'(rc16), 64'd1);
    tick();
    chk("uf_sticky", 64'(uf16), 64'h1);

    // Build level 500 via throttle_set, then reset mid-stream into seeded mode
    tval = 32'hFFFF_FFFF; tset = 1'b1;
    tick();
    tset = 1'b0;
    repeat (500) tick();
    chk("mid_ready", 64'(rdy16), 64'h0);
    chk("mid_uf", 64'(uf16), 64'h1);
    mode = 2'd3; seed = 32'h0; tval = 32'h0;
    do_reset();
    chk("rst2_data", d64, 64'h0);
    chk("rst2_ready", 64'(rdy64), 64'h0);
    chk("rst2_uf", 64'(uf64), 64'h0);
    chk("rst2_rc", 64'(rc64), 64'h0);
    tick();
    chk("seed_first", d64, 64'h09090909_00000001);
    repeat (5) tick();
    chk("seed_ready", 64'(rdy64), 64'h0);

    // Mode input change outside reset must not alter the stream type
    mode = 2'd0;
    rd = 1'b1; tick(); rd = 1'b0;
    tick();
    chk("mode_ignored", d64, 64'h12121212_00000002);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
